pc_sequencer: RTL and testbench

Program-counter and branch-resolution stage sitting directly downstream of the ALU status register. Consumes the registered carry (`C`) and zero (`Z`) flags, together with a decoded branch opcode and immediate target, and produces the next instruction address. It inserts a one-cycle flush bubble after every taken branch and latches a terminal halt state. An optional return-address stack supports call and return.

---
 rtl/pc_sequencer.sv | 87 ++++++++
 tb/tb_pc_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with branch resolution, a one-cycle flush after taken branches and a terminal halt.
// Define PC_STACK_EN to build the DEPTH-entry return-address stack for CALL/RET.
module pc_sequencer #(
    parameter int AW    = 4,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic [3:0]    OP,
    input  logic [AW-1:0] IM,
    input  logic          C,
    input  logic          Z,
    output logic [AW-1:0] PC,
    output logic          VALID,
    output logic          TAKEN,
    output logic          HALTED,
    output logic          ERR
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    state_t state, state_n;
    logic [AW-1:0] pc_n, pc_inc, stack_pc;
    logic taken_n, jump, stack_jump, run_go;
    assign pc_inc = PC + 1'b1;
    assign run_go = state == RUN && EN;
    assign VALID  = state == RUN;
    assign HALTED = state == HALT;
    assign jump = OP == 4'b0001 || (OP == 4'b0010 && !C) || (OP == 4'b0011 && C) ||
                  (OP == 4'b0100 && Z) || (OP == 4'b0101 && !Z);
`ifdef PC_STACK_EN
    localparam int SW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [SW-1:0] FULL = SW'(DEPTH);
    logic [AW-1:0] stk [DEPTH];
    logic [SW-1:0] sp, sp_m1;
    logic call, ret, push, pop;
    assign sp_m1 = sp - 1'b1;
    assign call = run_go && OP == 4'b1000;
    assign ret  = run_go && OP == 4'b1001;
    assign push = call && sp != FULL;
    assign pop  = ret && sp != '0;
    assign stack_jump = call || pop;
    assign stack_pc   = pop ? stk[sp_m1[IW-1:0]] : IM;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sp  <= '0;
            ERR <= 1'b0;
        end else begin
            ERR <= ERR | (call && !push) | (ret && !pop);
            sp  <= push ? sp + 1'b1 : pop ? sp_m1 : sp;
        end
    end
    // Storage needs no reset: entries are only read below the stack pointer.
    always_ff @(posedge CLK) begin
        if (push) stk[sp[IW-1:0]] <= pc_inc;
    end
`else
    assign stack_jump = 1'b0;
    assign stack_pc   = IM;
    assign ERR        = 1'b0;
`endif
    always_comb begin
        state_n = state;
        pc_n    = PC;
        taken_n = 1'b0;
        if (state == FLUSH) state_n = RUN;
        else if (run_go) begin
            if (OP == 4'b0110) state_n = HALT;
            else if (jump || stack_jump) begin
                pc_n    = stack_jump ? stack_pc : IM;
                state_n = FLUSH;
                taken_n = 1'b1;
            end else pc_n = pc_inc;
        end
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
            PC    <= '0;
            TAKEN <= 1'b0;
        end else begin
            state <= state_n;
            PC    <= pc_n;
            TAKEN <= taken_n;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer; define PC_STACK_EN to exercise the return stack.
module tb_pc_sequencer;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, c = 1'b0, z = 1'b0;
    logic [3:0] op = 4'd0, im = 4'd0;
    logic [3:0] pc;
    logic valid, taken, halted, err;
    int total = 0, passed = 0;

    typedef struct {
        logic [3:0] pc;
        logic v, t, h, e;
        string nm;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    pc_sequencer #(.AW(4), .DEPTH(4)) dut (
        .CLK(clk), .RST(rst), .EN(en), .OP(op), .IM(im), .C(c), .Z(z),
        .PC(pc), .VALID(valid), .TAKEN(taken), .HALTED(halted), .ERR(err)
    );

    always #5 clk = ~clk;

    task automatic check(input exp_t e);
        total++;
        if (pc === e.pc && valid === e.v && taken === e.t && halted === e.h && err === e.e) passed++;
        else $display("FAIL %s: got pc=%0d valid=%b taken=%b halted=%b err=%b, want pc=%0d valid=%b taken=%b halted=%b err=%b",
                      e.nm, pc, valid, taken, halted, err, e.pc, e.v, e.t, e.h, e.e);
    endtask

    // Monitor: outputs settled by the previous rising edge are compared at each falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check(mon_e);
        end
    end

    task automatic step(input logic e_in, input logic [3:0] o, input logic [3:0] i, input logic ci, input logic zi,
                        input logic [3:0] xp, input logic xv, input logic xt, input logic xh, input logic xe,
                        input string nm);
        @(negedge clk);
        #1;
        en = e_in; op = o; im = i; c = ci; z = zi;
        q.push_back('{xp, xv, xt, xh, xe, nm});
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk);
        #2 rst = 1'b1;
        en = 1'b0;
        #1 check('{4'd0, 1'b1, 1'b0, 1'b0, 1'b0, nm});
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

    initial begin
        #1 check('{4'd0, 1'b1, 1'b0, 1'b0, 1'b0, "reset"});
        #1 rst = 1'b0;
        for (int i = 0; i < 17; i++)
            step(1, 4'b0000, 4'd0, 0, 0, 4'((i + 1) & 15), 1, 0, 0, 0, "next_wrap");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd2, 1, 0, 0, 0, "next_to2");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd3, 1, 0, 0, 0, "next_to3");
        step(1, 4'b0010, 4'd9, 0, 0, 4'd9, 0, 1, 0, 0, "jnc_taken");
        step(1, 4'b0001, 4'd0, 0, 0, 4'd9, 1, 0, 0, 0, "flush_ignores_jmp");
        step(1, 4'b0001, 4'd3, 0, 0, 4'd3, 0, 1, 0, 0, "jmp3");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd3, 1, 0, 0, 0, "jmp3_flush");
        step(1, 4'b0010, 4'd9, 1, 0, 4'd4, 1, 0, 0, 0, "jnc_untaken");
        step(1, 4'b0011, 4'd9, 1, 0, 4'd9, 0, 1, 0, 0, "jc_taken");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd9, 1, 0, 0, 0, "jc_flush");
        step(1, 4'b0101, 4'd2, 0, 1, 4'd10, 1, 0, 0, 0, "jnz_untaken");
        step(1, 4'b0101, 4'd2, 0, 0, 4'd2, 0, 1, 0, 0, "jnz_taken");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd2, 1, 0, 0, 0, "jnz_flush");
        step(1, 4'b0100, 4'd9, 0, 0, 4'd3, 1, 0, 0, 0, "jz_untaken");
        step(1, 4'b0011, 4'd9, 0, 0, 4'd4, 1, 0, 0, 0, "jc_untaken");
        step(1, 4'b0111, 4'd9, 1, 1, 4'd5, 1, 0, 0, 0, "undef_op_next");
        step(1, 4'b0100, 4'd12, 0, 1, 4'd12, 0, 1, 0, 0, "jz_taken");
        step(0, 4'b0000, 4'd0, 0, 0, 4'd12, 1, 0, 0, 0, "jz_flush_en0");
        step(0, 4'b0001, 4'd3, 0, 0, 4'd12, 1, 0, 0, 0, "en0_hold_jmp");
        step(0, 4'b0000, 4'd0, 0, 0, 4'd12, 1, 0, 0, 0, "en0_hold_next");
        step(0, 4'b0110, 4'd0, 0, 0, 4'd12, 1, 0, 0, 0, "en0_hold_halt");
`ifndef PC_STACK_EN
        step(1, 4'b1000, 4'd8, 0, 0, 4'd13, 1, 0, 0, 0, "call_as_next");
        step(1, 4'b1001, 4'd8, 0, 0, 4'd14, 1, 0, 0, 0, "ret_as_next");
`endif
        step(1, 4'b0001, 4'd5, 0, 0, 4'd5, 0, 1, 0, 0, "jmp5");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd5, 1, 0, 0, 0, "jmp5_flush");
        step(1, 4'b0110, 4'd0, 0, 0, 4'd5, 0, 0, 1, 0, "halt");
        for (int i = 0; i < 10; i++)
            step(1, i[0] ? 4'b0001 : 4'b0000, 4'd9, 0, 0, 4'd5, 0, 0, 1, 0, "halt_hold");
        async_reset("rst_in_halt");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd1, 1, 0, 0, 0, "post_halt_next");
        step(1, 4'b0001, 4'd7, 0, 0, 4'd7, 0, 1, 0, 0, "jmp7");
        async_reset("rst_in_flush");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd1, 1, 0, 0, 0, "post_flush_next");
`ifdef PC_STACK_EN
        step(1, 4'b1000, 4'd8, 0, 0, 4'd8, 0, 1, 0, 0, "call1");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd8, 1, 0, 0, 0, "call1_flush");
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b1000, 4'd8, 0, 0, 4'd8, 0, 1, 0, 0, "call_n");
            step(1, 4'b0000, 4'd0, 0, 0, 4'd8, 1, 0, 0, 0, "call_n_flush");
        end
        step(1, 4'b1000, 4'd8, 0, 0, 4'd8, 0, 1, 0, 1, "call_overflow");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd8, 1, 0, 0, 1, "overflow_flush");
        for (int i = 0; i < 3; i++) begin
            step(1, 4'b1001, 4'd0, 0, 0, 4'd9, 0, 1, 0, 1, "ret9");
            step(1, 4'b0000, 4'd0, 0, 0, 4'd9, 1, 0, 0, 1, "ret9_flush");
        end
        step(1, 4'b1001, 4'd0, 0, 0, 4'd2, 0, 1, 0, 1, "ret2");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd2, 1, 0, 0, 1, "ret2_flush");
        step(1, 4'b1001, 4'd0, 0, 0, 4'd3, 1, 0, 0, 1, "ret_underflow");
        step(1, 4'b0000, 4'd0, 0, 0, 4'd4, 1, 0, 0, 1, "err_sticky");
        async_reset("rst_clears_err");
`else
        step(1, 4'b1000, 4'd8, 0, 0, 4'd2, 1, 0, 0, 0, "call_no_stack");
        step(1, 4'b1001, 4'd8, 0, 0, 4'd3, 1, 0, 0, 0, "ret_no_stack");
`endif
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
